// File: rtl/icache_responder.sv
// Direct-mapped instruction cache responder (4-word lines) between fetch and backing memory.
// Optional hit/miss counters are built only when ICACHE_PERF_EN is defined.
module icache_responder #(
   parameter int INDEX_BITS = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req,
   input  logic [31:0] addr,
   output logic [31:0] rdata,
   output logic        data_ok,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ok,
   output logic [31:0] hit_cnt,
   output logic [31:0] miss_cnt
);
   localparam int LINES = 1 << INDEX_BITS;
   localparam int TAG_W = 28 - INDEX_BITS;

   typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_REFILL, S_RESP} state_t;

   state_t                  r_state;
   state_t                  w_state_next;
   logic [31:0]             r_req_addr;
   logic [1:0]              r_cnt;
   logic [LINES-1:0]        r_valid;
   logic [TAG_W-1:0]        r_tag_mem  [LINES];
   logic [31:0]             r_data_mem [LINES*4];
   logic [TAG_W-1:0]        r_tag_q;
   logic [31:0]             r_data_q;
   logic [31:0]             r_rdata;

   logic [INDEX_BITS-1:0]   w_in_index;
   logic [INDEX_BITS-1:0]   w_req_index;
   logic [TAG_W-1:0]        w_req_tag;
   logic                    w_hit;
   logic                    w_lookup_hit;
   logic                    w_lookup_miss;
   logic                    w_fill_word;
   logic                    w_refill_done;
   logic                    w_unused;

   assign w_in_index    = addr[INDEX_BITS+3:4];
   assign w_req_index   = r_req_addr[INDEX_BITS+3:4];
   assign w_req_tag     = r_req_addr[31:INDEX_BITS+4];
   assign w_hit         = r_valid[w_req_index] && (r_tag_q == w_req_tag);
   assign w_lookup_hit  = (r_state == S_LOOKUP) && w_hit;
   assign w_lookup_miss = (r_state == S_LOOKUP) && !w_hit;
   assign w_fill_word   = (r_state == S_REFILL) && mem_ok;
   assign w_refill_done = w_fill_word && (r_cnt == 2'd3);
   assign w_unused      = ^{addr[1:0], r_req_addr[1:0]};

   // Tag and data arrays: read registered when a request is sampled, so the
   // lookup cycle sees them; writes only happen during refill.
   always_ff @(posedge clk) begin
      if (r_state == S_IDLE && req) begin
         r_tag_q  <= r_tag_mem[w_in_index];
         r_data_q <= r_data_mem[{w_in_index, addr[3:2]}];
      end
      if (resetn && w_fill_word)
         r_data_mem[{w_req_index, r_cnt}] <= mem_rdata;
      if (resetn && w_refill_done)
         r_tag_mem[w_req_index] <= w_req_tag;
   end

   generate
      for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
         always_ff @(posedge clk) begin
            if (!resetn)
               r_valid[gi] <= 1'b0;
            else if (w_refill_done && (w_req_index == INDEX_BITS'(gi)))
               r_valid[gi] <= 1'b1;
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state    <= S_IDLE;
         r_cnt      <= 2'd0;
         r_req_addr <= 32'd0;
         r_rdata    <= 32'd0;
      end else begin
         r_state <= w_state_next;
         if (r_state == S_IDLE && req)
            r_req_addr <= addr;
         if (r_state == S_LOOKUP)
            r_cnt <= 2'd0;
         else if (w_fill_word)
            r_cnt <= r_cnt + 2'd1;
         // Hold the last word actually delivered so rdata never shows stale X.
         if (w_lookup_hit)
            r_rdata <= r_data_q;
         else if (w_fill_word && (r_cnt == r_req_addr[3:2]))
            r_rdata <= mem_rdata;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:   if (req) w_state_next = S_LOOKUP;
         S_LOOKUP: w_state_next = w_hit ? S_IDLE : S_REFILL;
         S_REFILL: if (w_refill_done) w_state_next = req ? S_RESP : S_IDLE;
         S_RESP:   w_state_next = S_IDLE;
         default:  w_state_next = S_IDLE;
      endcase
   end

   assign mem_req  = (r_state == S_REFILL);
   assign mem_addr = (r_state == S_REFILL) ? {r_req_addr[31:4], r_cnt, 2'b00} : 32'd0;
   assign data_ok  = w_lookup_hit || (r_state == S_RESP);
   assign rdata    = w_lookup_hit ? r_data_q : r_rdata;

`ifdef ICACHE_PERF_EN
   logic [31:0] r_hit_cnt;
   logic [31:0] r_miss_cnt;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_hit_cnt  <= 32'd0;
         r_miss_cnt <= 32'd0;
      end else begin
         if (w_lookup_hit)
            r_hit_cnt <= r_hit_cnt + 32'd1;
         if (w_lookup_miss)
            r_miss_cnt <= r_miss_cnt + 32'd1;
      end
   end

   assign hit_cnt  = r_hit_cnt;
   assign miss_cnt = r_miss_cnt;
`else
   assign hit_cnt  = 32'd0;
   assign miss_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_icache_responder.sv
// Directed bench for icache_responder: vector table of fetches plus cancel, reset and spurious-ok sequences.
module tb_icache_responder;
   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        req = 1'b0;
   logic [31:0] addr = 32'd0;
   logic [31:0] rdata;
   logic        data_ok;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        mem_ok;
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;

`ifdef ICACHE_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   icache_responder #(.INDEX_BITS(4)) dut (
      .clk(clk), .resetn(resetn), .req(req), .addr(addr),
      .rdata(rdata), .data_ok(data_ok),
      .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_rdata(mem_rdata), .mem_ok(mem_ok),
      .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
   );

   always #5 clk = ~clk;

   // Memory model: mem_ok two cycles after each word request, data = word address.
   logic        model_ok = 1'b0;
   logic [31:0] model_data = 32'd0;
   logic        spur_ok = 1'b0;
   logic [31:0] spur_data = 32'd0;
   int          mem_wait = 0;
   int          fills = 0;
   logic [31:0] fill_q [$];
   int          dok_count = 0;

   assign mem_ok    = model_ok | spur_ok;
   assign mem_rdata = spur_ok ? spur_data : model_data;

   always @(negedge clk) begin
      model_ok = 1'b0;
      if (mem_req === 1'b1) begin
         if (mem_wait == 2) begin
            model_ok   = 1'b1;
            model_data = mem_addr;
            fill_q.push_back(mem_addr);
            fills++;
            mem_wait = 0;
         end else begin
            mem_wait++;
         end
      end else begin
         mem_wait = 0;
      end
   end

   always @(posedge clk) begin
      #1;
      if (data_ok === 1'b1) dok_count++;
   end

   int checks = 0;
   int errors = 0;
   int exp_hits = 0;
   int exp_misses = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   task automatic do_req(input logic [31:0] a, output int lat, output logic [31:0] data, output int ndok);
      int  dok0;
      bit  got;
      @(negedge clk);
      fill_q.delete();
      fills = 0;
      dok0  = dok_count;
      req   = 1'b1;
      addr  = a;
      lat   = 0;
      data  = 32'd0;
      got   = 1'b0;
      for (int c = 0; c < 200 && !got; c++) begin
         @(posedge clk);
         #1;
         lat++;
         if (data_ok === 1'b1) begin
            got  = 1'b1;
            data = rdata;
         end
      end
      req = 1'b0;
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL timeout req %h: no data_ok within 200 cycles", a);
      end
      @(negedge clk);
      @(negedge clk);
      ndok = dok_count - dok0;
   endtask

   typedef struct {
      logic [31:0] addr;
      logic        exp_hit;
      logic [31:0] exp_rdata;
      logic [31:0] fill_base;
   } vec_t;

   vec_t vecs [11];

   task automatic check_fills(input string tag, input logic [31:0] base);
      logic [31:0] got_a;
      check({tag, " nfill"}, fills, 4);
      for (int k = 0; k < 4; k++) begin
         got_a = (k < fill_q.size()) ? fill_q[k] : 32'h1;
         check($sformatf("%s fill%0d", tag, k), got_a, base + 32'(4 * k));
      end
   endtask

   task automatic check_perf(input string tag);
      check({tag, " hit_cnt"},  hit_cnt,  PERF ? 32'(exp_hits)   : 32'd0);
      check({tag, " miss_cnt"}, miss_cnt, PERF ? 32'(exp_misses) : 32'd0);
   endtask

   initial begin
      int          lat;
      int          ndok;
      int          dok0;
      logic [31:0] data;

      vecs[0]  = '{32'h0000_0034, 1'b0, 32'h0000_0034, 32'h0000_0030};
      vecs[1]  = '{32'h0000_0038, 1'b1, 32'h0000_0038, 32'h0};
      vecs[2]  = '{32'h0000_0030, 1'b1, 32'h0000_0030, 32'h0};
      vecs[3]  = '{32'h0000_0134, 1'b0, 32'h0000_0134, 32'h0000_0130};
      vecs[4]  = '{32'h0000_0034, 1'b0, 32'h0000_0034, 32'h0000_0030};
      vecs[5]  = '{32'h0000_013C, 1'b0, 32'h0000_013C, 32'h0000_0130};
      vecs[6]  = '{32'h0000_0200, 1'b0, 32'h0000_0200, 32'h0000_0200};
      vecs[7]  = '{32'h0000_0204, 1'b1, 32'h0000_0204, 32'h0};
      vecs[8]  = '{32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFF0};
      vecs[9]  = '{32'hFFFF_FFF3, 1'b1, 32'hFFFF_FFF0, 32'h0};
      vecs[10] = '{32'h0000_0134, 1'b1, 32'h0000_0134, 32'h0};

      // Reset state
      resetn = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      check("rst data_ok", {31'd0, data_ok}, 32'd0);
      check("rst mem_req", {31'd0, mem_req}, 32'd0);
      check("rst mem_addr", mem_addr, 32'd0);
      check("rst rdata", rdata, 32'd0);
      check_perf("rst");
      @(negedge clk);
      resetn = 1'b1;

      for (int i = 0; i < 11; i++) begin
         do_req(vecs[i].addr, lat, data, ndok);
         check($sformatf("v%0d rdata", i), data, vecs[i].exp_rdata);
         check($sformatf("v%0d latency", i), lat, vecs[i].exp_hit ? 32'd1 : 32'd14);
         check($sformatf("v%0d data_ok pulses", i), ndok, 32'd1);
         if (vecs[i].exp_hit) begin
            check($sformatf("v%0d nfill", i), fills, 32'd0);
            exp_hits++;
         end else begin
            check_fills($sformatf("v%0d", i), vecs[i].fill_base);
            exp_misses++;
         end
      end
      check_perf("table");

      // Cancel during refill: drop req after the second accepted word
      @(negedge clk);
      fill_q.delete();
      fills = 0;
      dok0  = dok_count;
      req   = 1'b1;
      addr  = 32'h0000_0400;
      for (int c = 0; c < 100 && fills < 2; c++) @(negedge clk);
      @(posedge clk); #1;
      req = 1'b0;
      for (int c = 0; c < 100 && mem_req === 1'b1; c++) begin
         @(posedge clk); #1;
      end
      check("cancel mem_req dropped", {31'd0, mem_req}, 32'd0);
      repeat (3) @(negedge clk);
      check_fills("cancel", 32'h0000_0400);
      check("cancel no data_ok", dok_count - dok0, 32'd0);
      exp_misses++;
      do_req(32'h0000_0408, lat, data, ndok);
      check("cancel rehit rdata", data, 32'h0000_0408);
      check("cancel rehit latency", lat, 32'd1);
      exp_hits++;
      check_perf("cancel");

      // Reset mid-refill, one cycle after the first accepted word
      @(negedge clk);
      fill_q.delete();
      fills = 0;
      req   = 1'b1;
      addr  = 32'h0000_0500;
      for (int c = 0; c < 100 && fills < 1; c++) @(negedge clk);
      @(posedge clk); #1;
      resetn = 1'b0;
      req    = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b1;
      check("midrst mem_req", {31'd0, mem_req}, 32'd0);
      check("midrst mem_addr", mem_addr, 32'd0);
      check("midrst data_ok", {31'd0, data_ok}, 32'd0);
      exp_hits   = 0;
      exp_misses = 0;
      check_perf("midrst");
      repeat (4) @(negedge clk);
      check("midrst stays idle", {31'd0, mem_req}, 32'd0);
      do_req(32'h0000_0500, lat, data, ndok);
      check("midrst rereq rdata", data, 32'h0000_0500);
      check("midrst rereq latency", lat, 32'd14);
      check_fills("midrst", 32'h0000_0500);
      exp_misses++;
      do_req(32'h0000_0038, lat, data, ndok);
      check("midrst old line rdata", data, 32'h0000_0038);
      check("midrst old line latency", lat, 32'd14);
      exp_misses++;

      // Spurious mem_ok in IDLE, then in LOOKUP
      @(negedge clk);
      spur_ok   = 1'b1;
      spur_data = 32'hDEAD_BEEF;
      dok0      = dok_count;
      @(posedge clk); #1;
      check("spur idle data_ok", {31'd0, data_ok}, 32'd0);
      check("spur idle mem_req", {31'd0, mem_req}, 32'd0);
      @(negedge clk);
      req  = 1'b1;
      addr = 32'h0000_0504;
      @(posedge clk); #1;
      check("spur lookup data_ok", {31'd0, data_ok}, 32'd1);
      check("spur lookup rdata", rdata, 32'h0000_0504);
      req = 1'b0;
      exp_hits++;
      @(posedge clk); #1;
      check("spur after data_ok", {31'd0, data_ok}, 32'd0);
      check("spur after mem_req", {31'd0, mem_req}, 32'd0);
      @(negedge clk);
      spur_ok = 1'b0;
      @(negedge clk);
      check("spur data_ok pulses", dok_count - dok0, 32'd1);
      do_req(32'h0000_0500, lat, data, ndok);
      check("spur word0 idx0 rdata", data, 32'h0000_0500);
      check("spur word0 idx0 latency", lat, 32'd1);
      exp_hits++;
      do_req(32'h0000_0030, lat, data, ndok);
      check("spur word0 idx3 rdata", data, 32'h0000_0030);
      check("spur word0 idx3 latency", lat, 32'd1);
      exp_hits++;
      check_perf("final");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
